// File: rtl/shift_register_param.sv
// shift_register_param: WIDTH-bit universal register (hold/load/clear/shift/rotate) with an
// FSM-sequenced multi-step shift/rotate; single-cycle ops take effect on the next edge.
// No backpressure: sequenced ops run to completion, and busy/done report progress.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   enable, mode, d     - single-cycle operation select and parallel load data
//   ser_in              - fill bit for logical shifts (sampled live on every step)
//   start, amount       - launch a sequenced shift/rotate of `amount` steps
//   q, ser_out          - register contents, last bit shifted/rotated out
//   busy, done          - sequenced-op running / one-cycle completion pulse
module shift_register_param #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  input  logic             start,
  input  logic [CW-1:0]    amount,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_out_q, ser_out_d;
  logic [2:0]       mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             do_step;
  logic [2:0]       step_mode;
  logic             start_seq;

  // Only the shift/rotate modes are worth sequencing; start with any other
  // mode degenerates to a plain single-cycle operation.
  assign start_seq = start && (mode >= M_SHL) && (mode <= M_ASR);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    do_step   = 1'b0;
    step_mode = mode;

    case (state_q)
      IDLE: begin
        if (start_seq) begin
          mode_d = mode;
          if (amount == '0) begin
            state_d = DONE;
          end else begin
            // First step happens on the start edge itself.
            state_d = RUN;
            do_step = 1'b1;
            cnt_d   = amount - CNT_ONE;
          end
        end else if (start || enable) begin
          do_step = 1'b1;
        end
      end
      RUN: begin
        step_mode = mode_q;
        // Count holds the steps still owed; once it is exhausted the FSM
        // spends this edge leaving RUN, so busy covers exactly `amount` cycles.
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          do_step = 1'b1;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    q_d       = q_q;
    ser_out_d = ser_out_q;
    if (do_step) begin
      case (step_mode)
        M_HOLD: q_d = q_q;
        M_LOAD: q_d = d;
        M_SHL: begin
          q_d       = {q_q[WIDTH-2:0], ser_in};
          ser_out_d = q_q[WIDTH-1];
        end
        M_SHR: begin
          q_d       = {ser_in, q_q[WIDTH-1:1]};
          ser_out_d = q_q[0];
        end
        M_ROL: begin
          q_d       = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          ser_out_d = q_q[WIDTH-1];
        end
        M_ROR: begin
          q_d       = {q_q[0], q_q[WIDTH-1:1]};
          ser_out_d = q_q[0];
        end
        M_ASR: begin
          q_d       = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          ser_out_d = q_q[0];
        end
        M_CLR: begin
          q_d       = '0;
          ser_out_d = 1'b0;
        end
        default: q_d = q_q;
      endcase
    end
  end

  // Status flags are registered copies of the next-state decode.
  assign busy_d = (state_d == RUN);
  assign done_d = (state_d == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      q_q       <= '0;
      ser_out_q <= 1'b0;
      mode_q    <= M_HOLD;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      ser_out_q <= ser_out_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign q       = q_q;
  assign ser_out = ser_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/shift_register_param.md
Name: shift_register_param

Overview:
- Parametrised successor to the team's 8-bit enable register: a WIDTH-bit universal register.
- Supports hold, parallel load, synchronous clear, and single-cycle shift/rotate operations.
- Also supports a multi-cycle sequenced shift/rotate by N positions, controlled by a small FSM with a busy/done handshake.
- Sits in datapaths (ALU shift unit, serialiser/deserialiser) wherever the plain enable register is insufficient.

Parameters:
- WIDTH, 8, register width in bits; legal range is 2 or more.
- CW, $clog2(WIDTH)+1, width of the amount port, so amounts 0..WIDTH are representable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  executes `mode` for one cycle; only honoured in IDLE.
- mode  input  3  operation select (encoding below).
- d  input  WIDTH  parallel load data.
- ser_in  input  1  fill bit for SHL/SHR.
- start  input  1  single-cycle pulse; begins a sequenced operation of `amount` steps.
- amount  input  CW  number of steps for a sequenced operation.
- q  output  WIDTH  register contents.
- ser_out  output  1  last bit shifted or rotated out (registered).
- busy  output  1  high while a sequenced operation is running.
- done  output  1  one-cycle pulse when a sequenced operation completes.

Behaviour:
- Reset: while rst=1 (asynchronous), q=0, ser_out=0, busy=0, done=0, FSM=IDLE. Reset mid-RUN aborts the operation; no done pulse follows.
- Mode encoding and one-step effect:
  - 000 HOLD: q unchanged.
  - 001 LOAD: q<=d.
  - 010 SHL: q<={q[W-2:0],ser_in}, ser_out<=q[W-1].
  - 011 SHR: q<={ser_in,q[W-1:1]}, ser_out<=q[0].
  - 100 ROL: q<={q[W-2:0],q[W-1]}, ser_out<=q[W-1].
  - 101 ROR: q<={q[0],q[W-1:1]}, ser_out<=q[0].
  - 110 ASR: q<={q[W-1],q[W-1:1]}, ser_out<=q[0].
  - 111 CLR: q<=0, ser_out<=0.
- ser_out changes only on shift/rotate steps and CLR.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 with mode in 010..110: capture mode and amount into internal registers. If amount=0, go to DONE. Otherwise go to RUN and perform the first step on this same edge; the remaining count becomes amount-1.
  - start=1 with mode in 000, 001 or 111: treated exactly as enable=1 (single-cycle op); no FSM transition, no done.
  - start=0, enable=1: perform one step of `mode` this edge; stay in IDLE.
  - start and enable both high: start takes priority.
- RUN:
  - busy=1. One step per clock using the captured mode; the count decrements.
  - When count reaches 0 after a step, go to DONE.
  - enable, start, mode, amount and d are ignored. ser_in is sampled live on every step.
- DONE: busy=0, done=1 for exactly one cycle, q held, then IDLE. start/enable are ignored in DONE.
- Latency: a sequenced operation with amount=N≥1 has busy high for N cycles and done asserted in cycle N+1 after the start edge. With amount=0, done is asserted the cycle after start and q is unchanged.
- amount>WIDTH is legal; each step still applies. Logical shifts saturate to fill bits; rotates wrap modulo WIDTH.
- busy and done are registered outputs.

Test Plan:
- Reset and load (WIDTH=8): assert rst mid-cycle -> q=0x00 immediately (asynchronous); enable=1, mode=001, d=0xA5 -> q=0xA5 next edge; mode=000 -> q stays 0xA5.
- Single steps: q=0x81, enable=1 with mode=010, ser_in=1 -> q=0x03, ser_out=1; then mode=110 -> q=0x01, ser_out=1; then mode=111 -> q=0x00.
- Sequenced rotate: q=0x96, start with mode=100, amount=3 -> busy high 3 cycles, q=0xB4 when done pulses, ser_out=0.
- Sequenced ASR with amount=0 and amount=9: q=0x80, amount=0 -> done next cycle, q=0x80; amount=9 -> q=0xFF after 9 busy cycles.
- Priority and ignore: start and enable high together -> sequenced op runs; during RUN drive enable=1, mode=001, d=0x00 -> no effect on q.
- Reset mid-RUN: SHR with amount=5 and rst asserted after 2 steps -> q=0, busy=0, no done pulse afterwards.
